digit_roi_sequencer: RTL
========================

# digit_roi_sequencer

Controller that sequences readout of the projection stage's column/row border RAMs once projection completes. It turns the stored border pairs into per-digit bounding boxes (ROIs), clamped to the active image. The ROIs are delivered one at a time over a valid/ready handshake to the downstream feature-extraction/recognition stage. It sits between the projection block and the recognizer and owns the border RAM read ports.

## Interface
Parameters:
- NUM_ROW, 1, max digit rows supported; row count is clamped to this.
- NUM_COL, 4, max digits per row; column count is clamped to this.
- DEPBIT, 12, border RAM address/data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- project_done  in  1  projection-complete level; its rising edge starts a scan.
- num_col  in  4  digit columns found.
- num_row  in  4  digit rows found.
- h_total_pexel  in  11  active width.
- v_total_pexel  in  11  active height.
- col_border_addr_rd  out  DEPBIT  column border RAM read address.
- col_border_data_rd  in  DEPBIT  column border data, valid 1 clk after address.
- row_border_addr_rd  out  DEPBIT  row border RAM read address.
- row_border_data_rd  in  DEPBIT  row border data, valid 1 clk after address.
- roi_valid  out  1  ROI fields are valid.
- roi_ready  in  1  downstream accepts the ROI.
- roi_left, roi_right, roi_top, roi_bottom  out  11 each  clamped box.
- roi_col, roi_row  out  4 each  digit indices.
- roi_last  out  1  final ROI of the frame.
- roi_bad  out  1  box is degenerate (left>right or top>bottom after clamping).
- busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse at scan end.

## Operation
- Border RAM layout:
  - Digit column c: left border at address 2c+1, right border at 2c+2.
  - Digit row r: top border at address 2r+1, bottom border at 2r+2.
- Start:
  - Registered edge detect on project_done.
  - A start is taken only in IDLE; edges while busy are ignored.
  - num_col and num_row are latched at start, each clamped to its parameter.
- Effective counts nc, nr:
  - If nc==0 or nr==0: go straight to DONE and emit no ROI.
  - Otherwise scan row-major: r outer, c inner.
- States and transitions:
  - IDLE → ROW_A.
  - ROW_A: row addr=2r+1. → ROW_B.
  - ROW_B: row addr=2r+2; capture top. → COL_A.
  - COL_A: col addr=2c+1; capture bottom if the previous state was ROW_B. → COL_B.
  - COL_B: col addr=2c+2; capture left. → CAP.
  - CAP: capture right; apply clamping. → EMIT.
  - EMIT: hold roi_valid until roi_ready.
    - On the handshake, if c<nc-1: c++ and go to COL_A.
    - Else if r<nr-1: c=0, r++ and go to ROW_A.
    - Else go to DONE.
  - DONE: pulse scan_done. → IDLE.
- Clamping (11-bit compare):
  - raw left ≥ h_total → 0 (covers underflow of the border-minus-2 value).
  - raw right ≥ h_total → h_total−1.
  - top and bottom use the same rules against v_total.
  - roi_bad = (left>right) | (top>bottom). The ROI is still emitted.
- Data and address width:
  - Only the low 11 bits of border data are used.
  - Address upper bits are zero.
- roi_last = (r==nr−1) & (c==nc−1) while in EMIT.

## Timing
- Reset values:
  - roi_valid, roi_last, roi_bad, busy, scan_done = 0.
  - All ROI fields, indices and RAM addresses = 0.
  - State = IDLE.
  - The edge-detect register = 0, so a project_done already high at reset release counts as a rising edge.
- First ROI latency:
  - project_done rises at cycle 0 and is registered.
  - ROW_A at cycle 1; roi_valid high at cycle 6.
- After a handshake at cycle t:
  - Next ROI in the same row: roi_valid at t+4.
  - First ROI of a new row: roi_valid at t+6.
- Handshake rules:
  - ROI fields are stable while roi_valid=1 && roi_ready=0.
  - roi_ready while roi_valid=0 is ignored.
  - roi_ready=1 held continuously causes no stall beyond the state latencies above.
- busy is 1 from ROW_A (or DONE, for empty scans) through DONE inclusive.
- scan_done coincides with the DONE state.
- Reset asserted mid-scan:
  - Abandons the scan immediately; all outputs take reset values.
  - No partial ROI is presented afterwards.
- A new project_done rise during DONE is ignored; one in IDLE starts a fresh scan.

## Structure
- Shared package `digit_pkg`:
  - State encoding localparams.
  - Border-address helper constants (left/top offset 1, right/bottom offset 2).
  - ROI field width (11).
- A natural sub-module is `border_clamp`: a combinational clamp plus bad flag, instantiated twice (h and v).
- Everything else lives in a single always-block FSM with registered outputs.

## Test plan
- nr=1, nc=4, col RAM {1:10,2:40,3:60,4:90,5:110,6:140,7:160,8:200}, row {1:20,2:120}, roi_ready=1 → 4 ROIs (10,40),(60,90),(110,140),(160,200), each with top=20 and bottom=120. First valid at cycle 6, subsequent spacing 4 clk, roi_last on the 4th, scan_done once.
- Same setup with roi_ready held low 10 clk on ROI 2 → fields are stable for the whole stall and no ROI is dropped or duplicated.
- Left raw=0xFFE (underflow), right raw=500, h_total=480 → roi_left=0, roi_right=479, roi_bad=0.
- num_col=0 → no roi_valid, busy for 1 clk, scan_done pulse.
- num_col=7 with NUM_COL=4 → exactly 4 ROIs; border addresses never exceed 8.
- Reset pulse during EMIT of ROI 2 → outputs reset immediately; the next project_done rise restarts at r=0, c=0.

Source files
------------

// File: rtl/digit_roi_sequencer_pkg.sv
// Shared definitions for the digit ROI sequencer.
// Contents:
//   - ROI coordinate width
//   - border RAM address offsets and an address helper
//   - FSM state encoding
package digit_pkg;

  // Width of every ROI coordinate and of the active-image size inputs.
  localparam int ROI_W = 11;

  // Within a digit column/row pair the low border sits at 2*idx+1 and the
  // high border at 2*idx+2.
  localparam logic [1:0] LO_OFS = 2'd1;
  localparam logic [1:0] HI_OFS = 2'd2;

  // State encoding.
  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_ROW_A = 3'd1;
  localparam logic [2:0] ENC_ROW_B = 3'd2;
  localparam logic [2:0] ENC_COL_A = 3'd3;
  localparam logic [2:0] ENC_COL_B = 3'd4;
  localparam logic [2:0] ENC_CAP   = 3'd5;
  localparam logic [2:0] ENC_EMIT  = 3'd6;
  localparam logic [2:0] ENC_DONE  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_ROW_A = ENC_ROW_A,
    ST_ROW_B = ENC_ROW_B,
    ST_COL_A = ENC_COL_A,
    ST_COL_B = ENC_COL_B,
    ST_CAP   = ENC_CAP,
    ST_EMIT  = ENC_EMIT,
    ST_DONE  = ENC_DONE
  } state_t;

  // Border RAM address for digit index idx and border offset ofs.
  function automatic logic [4:0] border_addr(input logic [3:0] idx,
                                             input logic [1:0] ofs);
    return {idx, 1'b0} + 5'(ofs);
  endfunction

endpackage

// File: rtl/digit_roi_sequencer_if.sv
// ROI delivery channel: valid/ready handshake carrying one clamped bounding
// box per transfer.
// Signals:
//   valid/ready            handshake
//   left/right/top/bottom  clamped box coordinates
//   col/row                digit indices
//   last                   final ROI of the frame
//   bad                    degenerate box after clamping
// Modports: master (producer), slave (consumer).
interface digit_roi_sequencer_if;
  import digit_pkg::*;

  logic             valid;
  logic             ready;
  logic [ROI_W-1:0] left;
  logic [ROI_W-1:0] right;
  logic [ROI_W-1:0] top;
  logic [ROI_W-1:0] bottom;
  logic [3:0]       col;
  logic [3:0]       row;
  logic             last;
  logic             bad;

  modport master (
    output valid, left, right, top, bottom, col, row, last, bad,
    input  ready
  );

  modport slave (
    input  valid, left, right, top, bottom, col, row, last, bad,
    output ready
  );
endinterface

// File: rtl/digit_roi_sequencer_border_clamp.sv
// Clamps one pair of raw borders (low/high) to an active extent.
// Ports:
//   lo_raw, hi_raw  in   raw border values
//   total           in   active extent (width or height)
//   lo, hi          out  clamped borders
//   bad             out  lo > hi after clamping
module border_clamp
  import digit_pkg::*;
(
  input  logic [ROI_W-1:0] lo_raw,
  input  logic [ROI_W-1:0] hi_raw,
  input  logic [ROI_W-1:0] total,
  output logic [ROI_W-1:0] lo,
  output logic [ROI_W-1:0] hi,
  output logic             bad
);

  // An out-of-range low border is usually a wrapped "border minus 2" value,
  // so it snaps to the image origin rather than to the far edge.
  assign lo  = (lo_raw >= total) ? '0 : lo_raw;
  assign hi  = (hi_raw >= total) ? (total - ROI_W'(1)) : hi_raw;
  assign bad = (lo > hi);

endmodule

// File: rtl/digit_roi_sequencer.sv
// Sequences readout of the column/row border RAMs after projection completes
// and delivers one clamped ROI per digit, row-major, over a valid/ready channel.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   project_done                 projection-complete level (rise starts a scan)
//   num_col, num_row             digit counts found (clamped to parameters)
//   h_total_pexel, v_total_pexel active image size
//   col_border_addr_rd/data_rd   column border RAM read port (1 clk latency)
//   row_border_addr_rd/data_rd   row border RAM read port (1 clk latency)
//   roi                          ROI output channel (master)
//   busy                         scan in progress
//   scan_done                    one-cycle pulse at scan end
module digit_roi_sequencer
  import digit_pkg::*;
#(
  parameter int NUM_ROW = 1,
  parameter int NUM_COL = 4,
  parameter int DEPBIT  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     project_done,
  input  logic [3:0]               num_col,
  input  logic [3:0]               num_row,
  input  logic [ROI_W-1:0]         h_total_pexel,
  input  logic [ROI_W-1:0]         v_total_pexel,
  output logic [DEPBIT-1:0]        col_border_addr_rd,
  input  logic [DEPBIT-1:0]        col_border_data_rd,
  output logic [DEPBIT-1:0]        row_border_addr_rd,
  input  logic [DEPBIT-1:0]        row_border_data_rd,
  digit_roi_sequencer_if.master    roi,
  output logic                     busy,
  output logic                     scan_done
);

  localparam logic [3:0] NC_MAX = 4'(NUM_COL);
  localparam logic [3:0] NR_MAX = 4'(NUM_ROW);

  state_t           state;
  logic             pd_reg;
  logic [3:0]       nc_reg;
  logic [3:0]       nr_reg;
  logic [3:0]       c_reg;
  logic [3:0]       r_reg;
  logic             from_row_reg;
  logic [ROI_W-1:0] top_raw_reg;
  logic [ROI_W-1:0] bottom_raw_reg;
  logic [ROI_W-1:0] left_raw_reg;

  logic [3:0]       nc_clamp;
  logic [3:0]       nr_clamp;
  logic             start;
  logic [ROI_W-1:0] col_data;
  logic [ROI_W-1:0] row_data;
  logic [ROI_W-1:0] h_lo, h_hi, v_lo, v_hi;
  logic             h_bad, v_bad;
  logic             unused_bits;

  assign nc_clamp = (num_col > NC_MAX) ? NC_MAX : num_col;
  assign nr_clamp = (num_row > NR_MAX) ? NR_MAX : num_row;
  assign start    = project_done & ~pd_reg;

  // Only the low ROI_W bits of each border word carry a coordinate.
  assign col_data    = col_border_data_rd[ROI_W-1:0];
  assign row_data    = row_border_data_rd[ROI_W-1:0];
  assign unused_bits = ^{col_border_data_rd[DEPBIT-1:ROI_W],
                         row_border_data_rd[DEPBIT-1:ROI_W]};

  // Horizontal clamp takes the right border straight from the RAM in CAP.
  border_clamp u_clamp_h (
    .lo_raw (left_raw_reg),
    .hi_raw (col_data),
    .total  (h_total_pexel),
    .lo     (h_lo),
    .hi     (h_hi),
    .bad    (h_bad)
  );

  border_clamp u_clamp_v (
    .lo_raw (top_raw_reg),
    .hi_raw (bottom_raw_reg),
    .total  (v_total_pexel),
    .lo     (v_lo),
    .hi     (v_hi),
    .bad    (v_bad)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      pd_reg             <= 1'b0;
      nc_reg             <= '0;
      nr_reg             <= '0;
      c_reg              <= '0;
      r_reg              <= '0;
      from_row_reg       <= 1'b0;
      top_raw_reg        <= '0;
      bottom_raw_reg     <= '0;
      left_raw_reg       <= '0;
      col_border_addr_rd <= '0;
      row_border_addr_rd <= '0;
      roi.valid          <= 1'b0;
      roi.left           <= '0;
      roi.right          <= '0;
      roi.top            <= '0;
      roi.bottom         <= '0;
      roi.col            <= '0;
      roi.row            <= '0;
      roi.last           <= 1'b0;
      roi.bad            <= 1'b0;
      busy               <= 1'b0;
      scan_done          <= 1'b0;
    end else begin
      pd_reg    <= project_done;
      scan_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            nc_reg <= nc_clamp;
            nr_reg <= nr_clamp;
            c_reg  <= '0;
            r_reg  <= '0;
            busy   <= 1'b1;
            if ((nc_clamp == 4'd0) || (nr_clamp == 4'd0)) begin
              state     <= ST_DONE;
              scan_done <= 1'b1;
            end else begin
              state              <= ST_ROW_A;
              row_border_addr_rd <= DEPBIT'(border_addr(4'd0, LO_OFS));
            end
          end
        end
        ST_ROW_A: begin
          row_border_addr_rd <= DEPBIT'(border_addr(r_reg, HI_OFS));
          state              <= ST_ROW_B;
        end
        ST_ROW_B: begin
          top_raw_reg        <= row_data;
          col_border_addr_rd <= DEPBIT'(border_addr(c_reg, LO_OFS));
          from_row_reg       <= 1'b1;
          state              <= ST_COL_A;
        end
        ST_COL_A: begin
          // Bottom is only in flight when we arrived here from the row fetch;
          // within a row the previous bottom stays valid.
          if (from_row_reg) begin
            bottom_raw_reg <= row_data;
          end
          from_row_reg       <= 1'b0;
          col_border_addr_rd <= DEPBIT'(border_addr(c_reg, HI_OFS));
          state              <= ST_COL_B;
        end
        ST_COL_B: begin
          left_raw_reg <= col_data;
          state        <= ST_CAP;
        end
        ST_CAP: begin
          roi.left   <= h_lo;
          roi.right  <= h_hi;
          roi.top    <= v_lo;
          roi.bottom <= v_hi;
          roi.bad    <= h_bad | v_bad;
          roi.col    <= c_reg;
          roi.row    <= r_reg;
          roi.last   <= (c_reg == nc_reg - 4'd1) && (r_reg == nr_reg - 4'd1);
          roi.valid  <= 1'b1;
          state      <= ST_EMIT;
        end
        ST_EMIT: begin
          if (roi.ready) begin
            roi.valid <= 1'b0;
            roi.last  <= 1'b0;
            if (c_reg != nc_reg - 4'd1) begin
              c_reg              <= c_reg + 4'd1;
              col_border_addr_rd <= DEPBIT'(border_addr(c_reg + 4'd1, LO_OFS));
              state              <= ST_COL_A;
            end else if (r_reg != nr_reg - 4'd1) begin
              c_reg              <= '0;
              r_reg              <= r_reg + 4'd1;
              row_border_addr_rd <= DEPBIT'(border_addr(r_reg + 4'd1, LO_OFS));
              state              <= ST_ROW_A;
            end else begin
              state     <= ST_DONE;
              scan_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
